// File: rtl/spi_mux_arbiter.sv
// Round-robin arbiter that shares one SPI master engine between NREQ clients,
// steering the SPI MUX, waiting for it to settle and acknowledging each transaction.
module spi_mux_arbiter #(
  parameter int NREQ           = 4,
  parameter int SETTLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic            sysClk,
  input  logic            sysReset_n,
  input  logic [NREQ-1:0] sysReq,
  output logic [NREQ-1:0] sysAck,
  output logic            sysAckErr,
  output logic [3:0]      muxSel,
  output logic            spiStart,
  input  logic            spiDone,
  input  logic            sysCsrStrobe,
  input  logic [31:0]     sysGpioOut,
  output logic [31:0]     sysCsr
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    START  = 3'd2,
    WAIT   = 3'd3,
    ACK    = 3'd4
  } state_t;

  localparam logic [7:0]      SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [15:0]     TO_LAST     = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]      LAST_REQ    = 4'(NREQ - 1);
  localparam logic [NREQ-1:0] ONE         = NREQ'(1);

  state_t      state, state_n;
  logic [3:0]  rr, cur, pick;
  logic        pick_vld;
  logic [4:0]  sum;
  logic [7:0]  settle_cnt;
  logic [15:0] to_cnt;
  logic [7:0]  tx_count;
  logic        err, to_err, stray_done;
  logic        timeout_hit;
  logic [15:0] req_ext;
  logic        gpio_unused;

  assign req_ext     = 16'(sysReq);
  assign gpio_unused = ^sysGpioOut[31:3];
  assign timeout_hit = (state == WAIT) && !spiDone && (to_cnt == TO_LAST);

  // Walk offsets from the highest down so the smallest offset from rr wins.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    sum      = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      sum = {1'b0, rr} + 5'(i);
      if (sum >= 5'(NREQ)) sum = sum - 5'(NREQ);
      if (req_ext[sum[3:0]]) begin
        pick     = sum[3:0];
        pick_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge sysClk or negedge sysReset_n) begin
    if (!sysReset_n) state <= IDLE;
    else             state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (pick_vld) state_n = (pick == muxSel) ? START : SETTLE;
      SETTLE:  if (!req_ext[cur])                 state_n = IDLE;
               else if (settle_cnt == SETTLE_LAST) state_n = START;
      START:   state_n = WAIT;
      WAIT:    if (spiDone || to_cnt == TO_LAST) state_n = ACK;
      ACK:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge sysClk or negedge sysReset_n) begin
    if (!sysReset_n) begin
      muxSel     <= '0;
      rr         <= '0;
      cur        <= '0;
      settle_cnt <= '0;
      to_cnt     <= '0;
      tx_count   <= '0;
      err        <= 1'b0;
      to_err     <= 1'b0;
      stray_done <= 1'b0;
      sysAck     <= '0;
      sysAckErr  <= 1'b0;
      spiStart   <= 1'b0;
    end else begin
      spiStart  <= 1'b0;
      sysAck    <= '0;
      sysAckErr <= 1'b0;
      case (state)
        IDLE: if (pick_vld) begin
          cur <= pick;
          if (pick != muxSel) begin
            muxSel     <= pick;
            settle_cnt <= '0;
          end
        end
        SETTLE: settle_cnt <= settle_cnt + 8'd1;
        START: begin
          spiStart <= 1'b1;
          to_cnt   <= '0;
        end
        WAIT: begin
          if (!spiDone && to_cnt != TO_LAST) to_cnt <= to_cnt + 16'd1;
          err <= timeout_hit;
        end
        ACK: begin
          sysAck    <= ONE << cur;
          sysAckErr <= err;
          rr        <= (cur == LAST_REQ) ? 4'd0 : cur + 4'd1;
        end
        default: ;
      endcase

      // Sticky flags: a set event in the same cycle as a CSR clear wins.
      if (timeout_hit)                           to_err <= 1'b1;
      else if (sysCsrStrobe && sysGpioOut[0])    to_err <= 1'b0;

      if (spiDone && state != WAIT)              stray_done <= 1'b1;
      else if (sysCsrStrobe && sysGpioOut[1])    stray_done <= 1'b0;

      if (state == ACK)                          tx_count <= tx_count + 8'd1;
      else if (sysCsrStrobe && sysGpioOut[2])    tx_count <= '0;
    end
  end

  assign sysCsr = {tx_count[6:0], to_err, stray_done, state, muxSel, req_ext};

endmodule

// File: tb/tb_spi_mux_arbiter.sv
// Bench for spi_mux_arbiter: directed vector table, hand-written corner sequences
// and randomized traffic scored against a transaction-level round-robin model.
module tb_spi_mux_arbiter;
  localparam int NREQ   = 4;
  localparam int SETTLE = 8;
  localparam int TMO    = 100;

  logic            sysClk = 1'b0;
  logic            sysReset_n = 1'b1;
  logic [NREQ-1:0] sysReq = '0;
  logic [NREQ-1:0] sysAck;
  logic            sysAckErr;
  logic [3:0]      muxSel;
  logic            spiStart;
  logic            spiDone = 1'b0;
  logic            sysCsrStrobe = 1'b0;
  logic [31:0]     sysGpioOut = '0;
  logic [31:0]     sysCsr;

  spi_mux_arbiter #(.NREQ(NREQ), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)) dut (
    .sysClk(sysClk), .sysReset_n(sysReset_n), .sysReq(sysReq), .sysAck(sysAck),
    .sysAckErr(sysAckErr), .muxSel(muxSel), .spiStart(spiStart), .spiDone(spiDone),
    .sysCsrStrobe(sysCsrStrobe), .sysGpioOut(sysGpioOut), .sysCsr(sysCsr)
  );

  always #5 sysClk = ~sysClk;

  typedef struct {
    logic [3:0] req;
    int         dly;
    int         grant;
    int         start_lat;
    int         ack_lat;
    logic       err;
  } row_t;

  row_t rows[12];
  int checks = 0, failures = 0, timeouts = 0;
  int done_delay = 0, eng_cnt = 0;
  int stray_cnt = 0, stray_seen = 0;

  // Engine model: pulse spiDone done_delay cycles after spiStart (0 = never answer).
  always @(negedge sysClk) begin
    spiDone = 1'b0;
    if (!sysReset_n) eng_cnt = 0;
    else begin
      if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) spiDone = 1'b1;
      end
      if (spiStart && done_delay > 0) eng_cnt = done_delay;
      if (stray_seen != stray_cnt) begin
        spiDone    = 1'b1;
        stray_seen = stray_cnt;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $finish;
  end

  task automatic finish_tb();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic wait_ev(input bit ack, input int budget, output int n);
    bit hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < budget) begin
      @(negedge sysClk);
      n++;
      hit = ack ? (sysAck != '0) : spiStart;
    end
    if (!hit) begin
      checks++;
      failures++;
      timeouts++;
      $display("FAIL wait_%s timed out after %0d cycles", ack ? "ack" : "start", n);
      if (timeouts >= 3) finish_tb();
    end
  endtask

  task automatic do_reset();
    sysReq = '0; sysCsrStrobe = 1'b0; sysGpioOut = '0; done_delay = 0;
    sysReset_n = 1'b0;
    repeat (3) @(negedge sysClk);
    sysReset_n = 1'b1;
    @(negedge sysClk);
  endtask

  task automatic csr_write(input logic [31:0] d);
    sysCsrStrobe = 1'b1; sysGpioOut = d;
    @(negedge sysClk);
    sysCsrStrobe = 1'b0; sysGpioOut = '0;
  endtask

  // Apply a request vector at the current falling edge and follow one transaction.
  task automatic run_row(input row_t r, input string tag);
    int n;
    sysReq = r.req; done_delay = r.dly;
    wait_ev(1'b0, 300, n);
    chk({tag, "_start_lat"}, 32'(n), 32'(r.start_lat));
    chk({tag, "_sel"}, 32'(muxSel), 32'(r.grant));
    wait_ev(1'b1, 300, n);
    chk({tag, "_ack_lat"}, 32'(n), 32'(r.ack_lat));
    chk({tag, "_ack_vec"}, 32'(sysAck), 32'(1 << r.grant));
    chk({tag, "_ack_err"}, 32'(sysAckErr), 32'(r.err));
  endtask

  function automatic int model_pick(input logic [3:0] rq, input int rr);
    for (int i = 0; i < NREQ; i++)
      if (rq[(rr + i) % NREQ]) return (rr + i) % NREQ;
    return -1;
  endfunction

  initial begin
    int n, starts, acks, g, m_rr, m_sel, m_cnt;
    logic [3:0] rq;
    row_t r;

    // Held-high requests rotate 0,1,2,3,0; then same-client, timeout and wrap cases.
    rows[0]  = '{4'b1111, 5,  0, 2,  7,  1'b0};
    rows[1]  = '{4'b1111, 5,  1, 10, 7,  1'b0};
    rows[2]  = '{4'b1111, 5,  2, 10, 7,  1'b0};
    rows[3]  = '{4'b1111, 5,  3, 10, 7,  1'b0};
    rows[4]  = '{4'b1111, 5,  0, 10, 7,  1'b0};
    rows[5]  = '{4'b0001, 3,  0, 2,  5,  1'b0};
    rows[6]  = '{4'b0001, 0,  0, 2,  101, 1'b1};
    rows[7]  = '{4'b0100, 20, 2, 10, 22, 1'b0};
    rows[8]  = '{4'b0010, 1,  1, 10, 3,  1'b0};
    rows[9]  = '{4'b1010, 2,  3, 10, 4,  1'b0};
    rows[10] = '{4'b1010, 2,  1, 10, 4,  1'b0};
    rows[11] = '{4'b1010, 2,  3, 10, 4,  1'b0};

    #1 sysReset_n = 1'b0;
    @(negedge sysClk);
    chk("rst_ack", 32'(sysAck), 0);
    chk("rst_start", 32'(spiStart), 0);
    chk("rst_err", 32'(sysAckErr), 0);
    chk("rst_csr", sysCsr, 0);
    sysReset_n = 1'b1;
    @(negedge sysClk);
    chk("post_rst_csr", sysCsr, 0);

    // First request to client 2 with full settle.
    sysReq = 4'b0100; done_delay = 20;
    @(negedge sysClk);
    chk("t1_muxsel", 32'(muxSel), 2);
    chk("t1_state_settle", 32'(sysCsr[22:20]), 1);
    wait_ev(1'b0, 300, n);
    chk("t1_settle_lat", 32'(n), 9);
    @(negedge sysClk);
    chk("t1_start_pulse", 32'(spiStart), 0);
    wait_ev(1'b1, 300, n);
    chk("t1_ack_lat", 32'(n + 1), 22);
    chk("t1_ack_vec", 32'(sysAck), 32'h4);
    chk("t1_ack_err", 32'(sysAckErr), 0);
    chk("t1_txcount", 32'(sysCsr[31:25]), 1);
    sysReq = '0;

    // Request dropped during settle, then a stray engine completion.
    @(negedge sysClk);
    sysReq = 4'b0010;
    @(negedge sysClk);
    chk("drop_muxsel", 32'(muxSel), 1);
    repeat (2) @(negedge sysClk);
    chk("drop_state_settle", 32'(sysCsr[22:20]), 1);
    sysReq = '0;
    starts = 0; acks = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge sysClk);
      if (spiStart) starts++;
      if (sysAck != '0) acks++;
    end
    chk("drop_starts", 32'(starts), 0);
    chk("drop_acks", 32'(acks), 0);
    chk("drop_state_idle", 32'(sysCsr[22:20]), 0);
    chk("drop_muxsel_kept", 32'(muxSel), 1);
    chk("stray_before", 32'(sysCsr[23]), 0);
    stray_cnt++;
    repeat (3) @(negedge sysClk);
    chk("stray_set", 32'(sysCsr[23]), 1);
    csr_write(32'h2);
    chk("stray_clr", 32'(sysCsr[23]), 0);

    do_reset();
    for (int i = 0; i < 12; i++) run_row(rows[i], "row");
    sysReq = '0;
    chk("rows_txcount", 32'(sysCsr[31:25]), 12);
    chk("toerr_set", 32'(sysCsr[24]), 1);
    csr_write(32'h1);
    chk("toerr_clr", 32'(sysCsr[24]), 0);

    // Clear write lands on the very edge the timeout fires.
    sysReq = 4'b1000; done_delay = 0;
    wait_ev(1'b0, 300, n);
    chk("tc_start_lat", 32'(n), 2);
    repeat (99) @(negedge sysClk);
    sysCsrStrobe = 1'b1; sysGpioOut = 32'h1;
    @(negedge sysClk);
    sysCsrStrobe = 1'b0; sysGpioOut = '0;
    chk("tc_toerr_kept", 32'(sysCsr[24]), 1);
    chk("tc_state_ack", 32'(sysCsr[22:20]), 4);
    @(negedge sysClk);
    chk("tc_ack_vec", 32'(sysAck), 32'h8);
    chk("tc_ack_err", 32'(sysAckErr), 1);
    sysReq = '0;
    chk("tc_txcount", 32'(sysCsr[31:25]), 13);
    csr_write(32'h4);
    chk("txcount_clr", 32'(sysCsr[31:25]), 0);

    // Randomized traffic: 256 transactions so txCount wraps back to zero.
    do_reset();
    m_rr = 0; m_sel = 0; m_cnt = 0;
    rq = 4'($urandom_range(1, 15));
    for (int t = 0; t < 256; t++) begin
      g = model_pick(rq, m_rr);
      r.req = rq;
      r.grant = g;
      r.start_lat = (g == m_sel) ? 2 : SETTLE + 2;
      r.dly = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 40));
      r.ack_lat = (r.dly == 0) ? TMO + 1 : r.dly + 2;
      r.err = (r.dly == 0);
      run_row(r, "rand");
      m_cnt++;
      chk("rand_txcount", 32'(sysCsr[31:25]), 32'(m_cnt % 128));
      m_rr = (g + 1) % NREQ;
      m_sel = g;
      rq[g] = 1'b0;
      rq = rq | 4'($urandom_range(0, 15));
      if (rq == 0) rq = 4'(1 << $urandom_range(0, 3));
    end
    sysReq = '0;

    // Move rr away from 0, then reset while the next transaction waits on the engine.
    r = '{4'b0100, 4, 2, (m_sel == 2) ? 2 : SETTLE + 2, 6, 1'b0};
    run_row(r, "pre_rst");
    sysReq = 4'b1000; done_delay = 50;
    wait_ev(1'b0, 300, n);
    repeat (3) @(negedge sysClk);
    chk("wait_state", 32'(sysCsr[22:20]), 3);
    #2 sysReset_n = 1'b0;
    #1;
    chk("async_ack", 32'(sysAck), 0);
    chk("async_err", 32'(sysAckErr), 0);
    chk("async_start", 32'(spiStart), 0);
    chk("async_muxsel", 32'(muxSel), 0);
    chk("async_csr_hi", 32'(sysCsr[31:16]), 0);
    sysReq = '0; done_delay = 0;
    @(negedge sysClk);
    @(negedge sysClk);
    sysReset_n = 1'b1;
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge sysClk);
      if (sysAck != '0) acks++;
    end
    chk("abort_no_ack", 32'(acks), 0);
    r = '{4'b1111, 5, 0, 2, 7, 1'b0};
    run_row(r, "post_rst");
    chk("post_rst_txcount", 32'(sysCsr[31:25]), 1);
    sysReq = '0;
    finish_tb();
  end
endmodule
